// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue
//
// Instruction-fetch front end. It owns the program counter and issues
// sequential word-aligned fetch addresses to an instruction memory with a
// registered read (data returns one cycle after the request). Returned
// instructions are buffered with their PCs in a small FIFO. The FIFO head is
// presented to decode over a valid/ready handshake. An execute-stage redirect
// flushes the FIFO, drops any response in flight and restarts fetch at the
// new target.
//
// Parameters:
//   DEPTH     queue entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk             clock, all state updates on the rising edge
//   reset           synchronous active-high reset
//   imem_req        fetch request this cycle
//   imem_addr       fetch byte address, bits [1:0] always zero
//   imem_rdata      instruction for the request issued in the previous cycle
//   redirect_valid  execute-stage redirect, single-cycle pulse
//   redirect_pc     redirect target, bits [1:0] ignored
//   id_valid        queue head valid
//   id_ready        decode accepts the head entry
//   id_instr        head instruction
//   id_pc           head PC
//   queue_count     current queue occupancy

module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [63:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect_valid,
    input  logic [63:0]              redirect_pc,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [31:0]              id_instr,
    output logic [63:0]              id_pc,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1'b1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1'b1);
    localparam logic [63:0]   ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

    logic [63:0]   fetch_pc_r;
    logic [63:0]   inflight_pc_r;
    logic          inflight_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;

    logic [63:0]   pc_mem_r    [DEPTH];
    logic [31:0]   instr_mem_r [DEPTH];

    logic [CW-1:0] occupancy_s;
    logic          issue_s;
    logic          push_s;
    logic          pop_s;

    // Issue/push/pop decisions. The credit check counts the in-flight response
    // as already occupying a slot, so a returning response always finds room.
    always_comb begin
        occupancy_s = count_r + {{(CW-1){1'b0}}, inflight_r};
        issue_s     = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        if (reset || redirect_valid) begin
            issue_s = 1'b0;
            push_s  = 1'b0;
        end else begin
            issue_s = (occupancy_s < DEPTH_C);
            push_s  = inflight_r;
        end
        pop_s = (count_r != {CW{1'b0}}) && id_ready;
    end

    assign imem_req    = issue_s;
    assign imem_addr   = fetch_pc_r & ALIGN_MASK;
    assign id_valid    = (count_r != {CW{1'b0}});
    assign id_instr    = instr_mem_r[rd_ptr_r];
    assign id_pc       = pc_mem_r[rd_ptr_r];
    assign queue_count = count_r;

    // Control state: PC, in-flight flag, queue pointers and occupancy.
    // Reset wins over redirect, which wins over normal fetch/queue traffic;
    // a pop coinciding with a redirect is simply discarded by the flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r    <= RESET_PC & ALIGN_MASK;
            inflight_pc_r <= RESET_PC & ALIGN_MASK;
            inflight_r    <= 1'b0;
            rd_ptr_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            count_r       <= {CW{1'b0}};
        end else if (redirect_valid) begin
            fetch_pc_r    <= redirect_pc & ALIGN_MASK;
            inflight_r    <= 1'b0;
            rd_ptr_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            count_r       <= {CW{1'b0}};
        end else begin
            if (issue_s) begin
                fetch_pc_r    <= fetch_pc_r + 64'd4;
                inflight_r    <= 1'b1;
                inflight_pc_r <= fetch_pc_r;
            end else begin
                inflight_r    <= 1'b0;
            end

            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end

            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end

            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage. Entries carry no reset: they are only observed while
    // id_valid is high, and every valid entry was written by a push.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r]    <= inflight_pc_r;
            instr_mem_r[wr_ptr_r] <= imem_rdata;
        end
    end

    fetch_prefetch_queue_checker #(
        .DEPTH (DEPTH)
    ) u_checker (
        .clk          (clk),
        .reset        (reset),
        .push         (push_s),
        .count        (count_r),
        .imem_addr_lo (imem_addr[1:0])
    );

endmodule

// fetch_prefetch_queue_checker
//
// Invariants of the prefetch queue: the credit scheme must never let a
// response land in a full queue, occupancy never exceeds DEPTH and fetch
// addresses stay word aligned.
//
// Ports:
//   clk           clock
//   reset         synchronous active-high reset (checks disabled while high)
//   push          response written into the queue this cycle
//   count         current queue occupancy
//   imem_addr_lo  low two bits of the fetch address

module fetch_prefetch_queue_checker #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [$clog2(DEPTH):0] count,
    input  logic [1:0]             imem_addr_lo
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (reset) !(push && (count == DEPTH_C))
    );

    a_count_in_range: assert property (
        @(posedge clk) disable iff (reset) (count <= DEPTH_C)
    );

    a_addr_aligned: assert property (
        @(posedge clk) disable iff (reset) (imem_addr_lo == 2'b00)
    );

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Testbench for fetch_prefetch_queue: registered instruction memory model,
// a scoreboard of expected PCs loaded whenever fetch is (re)started, and
// cycle-accurate checks of request/valid timing around reset and redirects.

module tb_fetch_prefetch_queue;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [63:0] id_pc;
    logic [2:0]  queue_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] exp_q [$];
    logic [63:0] exp_pc;
    int          nreq;

    fetch_prefetch_queue #(
        .DEPTH    (4),
        .RESET_PC (64'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .queue_count    (queue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] addr);
        case (addr)
            64'h0:   return 32'h00073A03;
            64'h4:   return 32'h00530AB3;
            64'h8:   return 32'h01583023;
            64'hC:   return 32'h01288863;
            default: return addr[31:0] ^ 32'h5A5A_0013;
        endcase
    endfunction

    task automatic check_value(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %h required %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Expected delivery order after fetch restarts at 'start'.
    task automatic load_expected(input logic [63:0] start);
        exp_q.delete();
        for (int i = 0; i < 48; i++) begin
            exp_q.push_back(start + 64'(4 * i));
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for one cycle and release; returns in cycle 0 after release.
    task automatic do_reset();
        next_cycle();
        reset = 1'b1;
        exp_q.delete();
        next_cycle();
        reset = 1'b0;
        load_expected(64'h0);
    endtask

    // Instruction memory: registered read, one-cycle latency.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= instr_of(imem_addr);
        else          imem_rdata <= 32'hDEAD_BEEF;
    end

    // Scoreboard: every handshake outside reset/redirect must match the next
    // expected PC and the instruction the memory holds at that PC.
    always @(negedge clk) begin
        if (!reset && !redirect_valid && id_valid && id_ready) begin
            check_value("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_pc = exp_q.pop_front();
                check_value("sb_pc", id_pc, exp_pc);
                check_value("sb_instr", 64'(id_instr), 64'(instr_of(exp_pc)));
            end
        end
    end

    initial begin
        reset          = 1'b1;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;

        // Reset state
        repeat (3) next_cycle();
        @(negedge clk);
        check_value("rst_req",   64'(imem_req),    64'd0);
        check_value("rst_addr",  imem_addr,        64'h0);
        check_value("rst_valid", 64'(id_valid),    64'd0);
        check_value("rst_count", 64'(queue_count), 64'd0);

        // Streaming
        next_cycle();
        reset    = 1'b0;
        id_ready = 1'b1;
        load_expected(64'h0);
        @(negedge clk);
        check_value("c0_req",   64'(imem_req), 64'd1);
        check_value("c0_addr",  imem_addr,     64'h0);
        check_value("c0_valid", 64'(id_valid), 64'd0);
        next_cycle();
        @(negedge clk);
        check_value("c1_addr",  imem_addr,     64'h4);
        check_value("c1_valid", 64'(id_valid), 64'd0);
        next_cycle();
        @(negedge clk);
        check_value("c2_valid", 64'(id_valid), 64'd1);
        check_value("c2_pc",    id_pc,         64'h0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            @(negedge clk);
            check_value("stream_valid", 64'(id_valid), 64'd1);
        end

        // Backpressure from reset
        next_cycle();
        id_ready = 1'b0;
        do_reset();
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            nreq += int'(imem_req);
            next_cycle();
        end
        @(negedge clk);
        check_value("bp_nreq",  64'(nreq),        64'd4);
        check_value("bp_req",   64'(imem_req),    64'd0);
        check_value("bp_count", 64'(queue_count), 64'd4);
        check_value("bp_pc",    id_pc,            64'h0);
        check_value("bp_instr", 64'(id_instr),    64'h00073A03);
        next_cycle();
        id_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_value("bp_drain_valid", 64'(id_valid), 64'd1);
            if (i == 0) check_value("bp_no_req_full", 64'(imem_req), 64'd0);
            if (i == 1) begin
                check_value("bp_resume_req",  64'(imem_req), 64'd1);
                check_value("bp_resume_addr", imem_addr,     64'h10);
            end
            next_cycle();
        end

        // Redirect while full
        id_ready = 1'b0;
        for (int i = 0; i < 8; i++) next_cycle();
        @(negedge clk);
        check_value("rf_full", 64'(queue_count), 64'd4);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1C;
        load_expected(64'h1C);
        @(negedge clk);
        check_value("rf_req_blocked", 64'(imem_req), 64'd0);
        next_cycle();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        @(negedge clk);
        check_value("rf_count", 64'(queue_count), 64'd0);
        check_value("rf_req",   64'(imem_req),    64'd1);
        check_value("rf_addr",  imem_addr,        64'h1C);
        check_value("rf_valid1", 64'(id_valid),   64'd0);
        next_cycle();
        @(negedge clk);
        check_value("rf_valid2", 64'(id_valid), 64'd0);
        next_cycle();
        @(negedge clk);
        check_value("rf_valid3", 64'(id_valid), 64'd1);
        check_value("rf_pc",     id_pc,         64'h1C);
        repeat (4) next_cycle();

        // Redirect colliding with the response for 0x8
        do_reset();
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check_value("col_addr8", imem_addr, 64'h8);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        load_expected(64'h40);
        @(negedge clk);
        check_value("col_req_blocked", 64'(imem_req), 64'd0);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check_value("col_addr40", imem_addr, 64'h40);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_value("col_pc", id_pc, 64'h40);
        repeat (3) next_cycle();

        // Misaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1F;
        load_expected(64'h1C);
        @(negedge clk);
        check_value("mis_req_blocked", 64'(imem_req), 64'd0);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check_value("mis_addr", imem_addr, 64'h1C);
        repeat (4) next_cycle();

        // Redirect to the top of the address space, then wrap to 0
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        load_expected(64'hFFFF_FFFF_FFFF_FFFC);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check_value("wrap_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        next_cycle();
        @(negedge clk);
        check_value("wrap_addr_zero", imem_addr, 64'h0);
        repeat (5) next_cycle();

        // Reset mid-stream: 3 entries queued and the 0xC request in flight
        id_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            next_cycle();
        end
        check_value("mr_count3", 64'(queue_count), 64'd3);
        check_value("mr_no_req", 64'(imem_req),    64'd0);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_value("mr_req_in_reset", 64'(imem_req), 64'd0);
        next_cycle();
        reset    = 1'b0;
        id_ready = 1'b1;
        load_expected(64'h0);
        @(negedge clk);
        check_value("mr_valid", 64'(id_valid),    64'd0);
        check_value("mr_count", 64'(queue_count), 64'd0);
        check_value("mr_req",   64'(imem_req),    64'd1);
        check_value("mr_addr",  imem_addr,        64'h0);
        next_cycle();
        @(negedge clk);
        check_value("mr_valid_c1", 64'(id_valid), 64'd0);
        repeat (6) next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
